intr_ctrl: RTL and testbench
============================

# intr_ctrl

Interrupt controller feeding the 8-bit pipelined CPU's single `INTR_in` line. It performs the following steps:
- synchronises up to `N_SRC` asynchronous external interrupt lines;
- detects rising edges and latches them as pending requests;
- applies a per-source mask;
- selects the highest-priority unmasked request;
- runs a request/acknowledge/done handshake with the CPU, so only one interrupt is in service at a time.

## Interface
Parameters:
- `N_SRC`, 4, number of interrupt sources (2..8).
- `ID_W`, 2, width of the granted-source index; must satisfy 2^`ID_W` >= `N_SRC`.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `IRQ`  in  `N_SRC`  external interrupt lines, asynchronous to `CLK`, rising-edge sensitive.
- `MASK_WE`  in  1  when high, `MASK` loads `MASK_DATA` at the next edge.
- `MASK_DATA`  in  `N_SRC`  new mask value; bit = 1 masks that source.
- `INTR_ACK`  in  1  one-cycle pulse from the CPU when it takes the interrupt.
- `INTR_DONE`  in  1  one-cycle pulse from the CPU when the handler retires (RTI).
- `INTR_OUT`  out  1  interrupt request to the CPU's `INTR_in`.
- `INTR_ID`  out  `ID_W`  index of the granted source.
- `PENDING`  out  `N_SRC`  pending-request register.
- `MASK`  out  `N_SRC`  current mask register.

## Operation
- **Synchroniser:** each `IRQ` bit passes through a 2-flop synchroniser followed by a third "previous" flop.
  - `rise[i]` = sync2[i] & ~prev[i].
- **Pending register:**
  - Set: `PENDING[i]` is set on `rise[i]`.
  - Clear: `PENDING[i]` is cleared when `INTR_ACK` is accepted for source i.
  - Simultaneous set and clear on the same bit: set wins, so the new edge is preserved as a fresh request.
- **Mask:**
  - `eligible` = `PENDING` & ~`MASK`.
  - Masked requests stay pending and become eligible as soon as they are unmasked.
  - A `MASK` write takes effect from the following cycle.
- **Priority:** fixed; the lowest eligible index wins.
- **FSM states:** IDLE, REQ, SERVICE.
  - IDLE -> REQ when `eligible` is non-zero. On this transition, `INTR_ID` latches the winner and `INTR_OUT` goes to 1.
  - REQ -> SERVICE on `INTR_ACK`. On this transition, `INTR_OUT` goes to 0 and `PENDING[INTR_ID]` is cleared.
  - REQ holds while `INTR_ACK` = 0. `INTR_ID` stays frozen even if a higher-priority source becomes eligible; there is no pre-emption.
  - SERVICE -> IDLE on `INTR_DONE`.
  - No nesting: new edges still set `PENDING`, but no request is raised until IDLE is reached.
- **Ignored inputs:**
  - `INTR_ACK` outside REQ.
  - `INTR_DONE` outside SERVICE.
- **Masking during REQ:** if the granted source is masked while in REQ, the request is still completed; `MASK` is only consulted in IDLE.
- **Reset (asynchronous, any state, including mid-handshake):**
  - State returns to IDLE.
  - `INTR_OUT` = 0, `INTR_ID` = 0, `PENDING` = 0, `MASK` = all ones (all sources masked).
  - All synchroniser and "previous" flops are cleared to 0.
  - Consequence: an `IRQ` line held high across reset release registers exactly one edge.

## Timing
- **Request latency:** from the first rising edge at which `IRQ[i]` is sampled high to the edge at which `INTR_OUT` rises is 4 edges.
  - Edge 1: sync1 captures.
  - Edge 2: sync2 captures; `rise` is asserted.
  - Edge 3: `PENDING` is set.
  - Edge 4: FSM enters REQ.
- **Pulse width:** `IRQ` pulses shorter than one `CLK` period may be missed. Sources must hold `IRQ` high for at least 2 cycles.
- **Acknowledge:** `INTR_OUT` falls at the edge that samples `INTR_ACK` = 1.
- **Back-to-back requests:**
  - After `INTR_DONE` is sampled, the FSM is in IDLE for exactly 1 cycle.
  - If `eligible` is non-zero, `INTR_OUT` rises at the next edge: 2 edges after `INTR_DONE` was sampled.
- **Output stability:** all outputs are registered. `INTR_ID` is stable from REQ entry until the next REQ entry.

## Test plan
- **Reset defaults and mask gating:**
  - Stimulus: assert `RST` with `IRQ` = 0, release `RST`, then pulse `IRQ[2]` for 3 cycles while `MASK` = 4'b1111.
  - Required: all outputs are at their reset values; `PENDING` = 4'b0100 and `INTR_OUT` stays 0.
- **Unmask and full handshake:**
  - Stimulus: from the previous state, write `MASK` = 0.
  - Required: `INTR_OUT` = 1 with `INTR_ID` = 2 at the second edge after the write.
  - Stimulus: pulse `INTR_ACK`.
  - Required: `INTR_OUT` = 0 and `PENDING` = 0 at that edge.
  - Stimulus: pulse `INTR_DONE`.
  - Required: FSM returns to IDLE with no further request.
- **Priority and no pre-emption:**
  - Stimulus: with `MASK` = 0, raise `IRQ[3]` and `IRQ[1]` on the same cycle.
  - Required: `INTR_ID` = 1 at 4 edges.
  - Stimulus: raise `IRQ[0]` while in REQ.
  - Required: `INTR_ID` stays 1.
  - Stimulus: complete the handshake.
  - Required: the next grant is `INTR_ID` = 0, followed by `INTR_ID` = 3.
- **Set/clear collision:**
  - Stimulus: time a new `IRQ[1]` rising edge so that `rise[1]` coincides with the accepted `INTR_ACK` for source 1.
  - Required: `PENDING[1]` stays 1, and a second request for source 1 follows `INTR_DONE`.
- **Spurious handshake inputs:**
  - Stimulus: pulse `INTR_DONE` in IDLE and `INTR_ACK` in IDLE and in SERVICE.
  - Required: no state change and no change to `PENDING`.
- **Reset mid-operation:**
  - Stimulus: assert `RST` asynchronously (between clock edges) while in SERVICE with `PENDING` = 4'b1000 and `IRQ[3]` held high.
  - Required: outputs clear immediately, without waiting for a clock edge.
  - Stimulus: after release, write `MASK` = 0.
  - Required: exactly one request, for source 3.

Source files
------------

// File: rtl/intr_ctrl_if.sv
// Interrupt-controller bus between the controller and the CPU/interrupt side.
// The master drives the IRQ lines, mask writes and ACK/DONE; the slave returns the request, ID and status.
interface intr_ctrl_if #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
);
  logic [N_SRC-1:0] IRQ;
  logic             MASK_WE;
  logic [N_SRC-1:0] MASK_DATA;
  logic             INTR_ACK;
  logic             INTR_DONE;
  logic             INTR_OUT;
  logic [ID_W-1:0]  INTR_ID;
  logic [N_SRC-1:0] PENDING;
  logic [N_SRC-1:0] MASK;

  modport master (
    output IRQ, MASK_WE, MASK_DATA, INTR_ACK, INTR_DONE,
    input  INTR_OUT, INTR_ID, PENDING, MASK
  );

  modport slave (
    input  IRQ, MASK_WE, MASK_DATA, INTR_ACK, INTR_DONE,
    output INTR_OUT, INTR_ID, PENDING, MASK
  );
endinterface

// File: rtl/intr_ctrl.sv
// Edge-triggered, fixed-priority interrupt controller that raises INTR_OUT 4 edges after IRQ is first sampled high.
// Only one request is in flight; new edges are held in PENDING until the ACK/DONE handshake returns to IDLE.
module intr_ctrl #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  intr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             out_q, out_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] sync1_q, sync2_q, prev_q;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  win_id;
  logic             ack_acc;

  // Reset clears the sync chain, so a line held high across reset yields one edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= bus.IRQ;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise     = sync2_q & ~prev_q;
  assign eligible = pend_q & ~mask_q;
  assign ack_acc  = (state_q == REQ) && bus.INTR_ACK;

  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  // A fresh edge on the bus being acknowledged survives as a new request.
  always_comb begin
    clr = '0;
    if (ack_acc) clr = N_SRC'(1) << id_q;
    pend_d = (pend_q & ~clr) | rise;
  end

  always_comb begin
    mask_d = mask_q;
    if (bus.MASK_WE) mask_d = bus.MASK_DATA;
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = REQ;
          out_d   = 1'b1;
          id_d    = win_id;
        end
      end
      REQ: begin
        if (bus.INTR_ACK) begin
          state_d = SERVICE;
          out_d   = 1'b0;
        end
      end
      SERVICE: begin
        if (bus.INTR_DONE) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        out_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      out_q   <= 1'b0;
      id_q    <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.INTR_OUT = out_q;
  assign bus.INTR_ID  = id_q;
  assign bus.PENDING  = pend_q;
  assign bus.MASK     = mask_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: cycle vector table for reset/mask/handshake, hand sequences for the corner cases,
// and a grant scoreboard that pops an expected ID on every INTR_OUT rising edge.
module tb_intr_ctrl;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_bad;
  int   exp_q[$];
  logic mon_prev;

  intr_ctrl_if #(.N_SRC(4), .ID_W(2)) bus ();

  intr_ctrl #(.N_SRC(4), .ID_W(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] irq;
    logic       mwe;
    logic [3:0] mdat;
    logic       ack;
    logic       done;
    int         push;
    logic       out;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] mask;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic drive(input logic [3:0] irq, input logic ack, input logic done);
    bus.IRQ       = irq;
    bus.INTR_ACK  = ack;
    bus.INTR_DONE = done;
    bus.MASK_WE   = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic out, input logic [1:0] id, input logic [3:0] pend);
    chk({nm, ".out"}, int'(bus.INTR_OUT), int'(out));
    chk({nm, ".id"}, int'(bus.INTR_ID), int'(id));
    chk({nm, ".pend"}, int'(bus.PENDING), int'(pend));
  endtask

  // Scoreboard: every request raised to the CPU must match the next queued grant.
  always begin
    @(posedge CLK);
    #1;
    if (bus.INTR_OUT && !mon_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL grant: unexpected request id=%0d, expected none (t=%0t)", bus.INTR_ID, $time);
      end else begin
        chk("grant.id", int'(bus.INTR_ID), exp_q.pop_front());
      end
    end
    mon_prev = bus.INTR_OUT;
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    mon_prev = 1'b0;
    RST      = 1'b1;
    bus.IRQ       = '0;
    bus.MASK_WE   = 1'b0;
    bus.MASK_DATA = '0;
    bus.INTR_ACK  = 1'b0;
    bus.INTR_DONE = 1'b0;

    //            irq     mwe  mdat  ack  done push  out  id     pend     mask
    tbl[0]  = '{4'b0100, 1'b0, 4'h0, 1'b0, 1'b0, -1, 1'b0, 2'd0, 4'b0000, 4'hF};
    tbl[1]  = '{4'b0100, 1'b0, 4'h0, 1'b0, 1'b0, -1, 1'b0, 2'd0, 4'b0000, 4'hF};
    tbl[2]  = '{4'b0100, 1'b0, 4'h0, 1'b0, 1'b0, -1, 1'b0, 2'd0, 4'b0100, 4'hF};
    tbl[3]  = '{4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, -1, 1'b0, 2'd0, 4'b0100, 4'hF};
    tbl[4]  = '{4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, -1, 1'b0, 2'd0, 4'b0100, 4'hF};
    tbl[5]  = '{4'b0000, 1'b1, 4'h0, 1'b0, 1'b0,  2, 1'b0, 2'd0, 4'b0100, 4'h0};
    tbl[6]  = '{4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, -1, 1'b1, 2'd2, 4'b0100, 4'h0};
    tbl[7]  = '{4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, -1, 1'b1, 2'd2, 4'b0100, 4'h0};
    tbl[8]  = '{4'b0000, 1'b0, 4'h0, 1'b1, 1'b0, -1, 1'b0, 2'd2, 4'b0000, 4'h0};
    tbl[9]  = '{4'b0000, 1'b0, 4'h0, 1'b1, 1'b0, -1, 1'b0, 2'd2, 4'b0000, 4'h0};
    tbl[10] = '{4'b0000, 1'b0, 4'h0, 1'b0, 1'b1, -1, 1'b0, 2'd2, 4'b0000, 4'h0};
    tbl[11] = '{4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, -1, 1'b0, 2'd2, 4'b0000, 4'h0};
    tbl[12] = '{4'b0000, 1'b0, 4'h0, 1'b0, 1'b1, -1, 1'b0, 2'd2, 4'b0000, 4'h0};
    tbl[13] = '{4'b0000, 1'b0, 4'h0, 1'b1, 1'b0, -1, 1'b0, 2'd2, 4'b0000, 4'h0};

    tick();
    tick();
    chk_out("reset", 1'b0, 2'd0, 4'b0000);
    chk("reset.mask", int'(bus.MASK), 15);
    RST = 1'b0;

    for (int v = 0; v < 14; v++) begin
      bus.IRQ       = tbl[v].irq;
      bus.MASK_WE   = tbl[v].mwe;
      bus.MASK_DATA = tbl[v].mdat;
      bus.INTR_ACK  = tbl[v].ack;
      bus.INTR_DONE = tbl[v].done;
      if (tbl[v].push >= 0) exp_q.push_back(tbl[v].push);
      tick();
      chk_out($sformatf("vec%0d", v), tbl[v].out, tbl[v].id, tbl[v].pend);
      chk($sformatf("vec%0d.mask", v), int'(bus.MASK), int'(tbl[v].mask));
    end
    drive(4'b0000, 1'b0, 1'b0);
    tick();

    // Priority with no pre-emption: 1 beats 3, later 0 must wait for the handshake.
    exp_q.push_back(1);
    drive(4'b1010, 1'b0, 1'b0);
    tick();
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    chk_out("prio.e3", 1'b0, 2'd2, 4'b1010);
    tick();
    chk_out("prio.e4", 1'b1, 2'd1, 4'b1010);
    drive(4'b0001, 1'b0, 1'b0);
    tick();
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    chk_out("prio.hold", 1'b1, 2'd1, 4'b1011);
    drive(4'b0000, 1'b1, 1'b0);
    tick();
    chk_out("prio.ack1", 1'b0, 2'd1, 4'b1001);
    exp_q.push_back(0);
    drive(4'b0000, 1'b0, 1'b1);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    chk_out("prio.g0", 1'b1, 2'd0, 4'b1001);
    drive(4'b0000, 1'b1, 1'b0);
    tick();
    exp_q.push_back(3);
    drive(4'b0000, 1'b0, 1'b1);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    chk_out("prio.g3", 1'b1, 2'd3, 4'b1000);
    drive(4'b0000, 1'b1, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 1'b1);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    chk_out("prio.end", 1'b0, 2'd3, 4'b0000);

    // Set/clear collision: second IRQ[1] edge lands on the ACK edge.
    exp_q.push_back(1);
    drive(4'b0010, 1'b0, 1'b0);
    tick();
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    chk_out("coll.req", 1'b1, 2'd1, 4'b0010);
    drive(4'b0010, 1'b0, 1'b0);
    tick();
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    tick();
    chk_out("coll.ack", 1'b0, 2'd1, 4'b0010);
    exp_q.push_back(1);
    drive(4'b0000, 1'b0, 1'b1);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    chk_out("coll.req2", 1'b1, 2'd1, 4'b0010);
    drive(4'b0000, 1'b1, 1'b0);
    tick();
    chk_out("coll.ack2", 1'b0, 2'd1, 4'b0000);
    drive(4'b0000, 1'b0, 1'b1);
    tick();
    drive(4'b0000, 1'b0, 1'b0);

    // Reset mid-SERVICE with IRQ[3] held high.
    exp_q.push_back(0);
    drive(4'b1001, 1'b0, 1'b0);
    tick();
    tick();
    drive(4'b1000, 1'b0, 1'b0);
    tick();
    tick();
    chk_out("rst.req", 1'b1, 2'd0, 4'b1001);
    drive(4'b1000, 1'b1, 1'b0);
    tick();
    drive(4'b1000, 1'b0, 1'b0);
    chk_out("rst.svc", 1'b0, 2'd0, 4'b1000);
    #1;
    RST = 1'b1;
    #1;
    chk_out("rst.async", 1'b0, 2'd0, 4'b0000);
    chk("rst.async.mask", int'(bus.MASK), 15);
    tick();
    RST = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk_out("rst.masked", 1'b0, 2'd0, 4'b1000);
    exp_q.push_back(3);
    bus.MASK_WE   = 1'b1;
    bus.MASK_DATA = 4'h0;
    tick();
    bus.MASK_WE   = 1'b0;
    tick();
    chk_out("rst.req3", 1'b1, 2'd3, 4'b1000);
    drive(4'b1000, 1'b1, 1'b0);
    tick();
    drive(4'b1000, 1'b0, 1'b1);
    tick();
    drive(4'b1000, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) tick();
    chk_out("rst.once", 1'b0, 2'd3, 4'b0000);
    chk("sb.leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
